// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - wait-state memory responder for the CU memory bus with side-band preload
module mem_responder #(
    parameter int adlines    = 8,
    parameter int datalines  = 16,
    parameter int memdepth   = 256,
    parameter int waitstates = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [adlines-1:0]   addressbus,
    input  logic [datalines-1:0] toram,
    input  logic                 read,
    input  logic                 write,
    output logic [datalines-1:0] fromram,
    output logic                 ready,
    output logic                 busy,
    output logic                 err,
    input  logic                 load_en,
    input  logic [adlines-1:0]   load_addr,
    input  logic [datalines-1:0] load_data
);

    localparam int aw = (memdepth > 1) ? $clog2(memdepth) : 1;
    localparam logic [adlines:0] depth_lim = (adlines+1)'(memdepth);
    localparam logic [3:0] ws4 = 4'(waitstates);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                 state, state_nx;
    logic [3:0]             cnt;
    logic [adlines-1:0]     lat_addr;
    logic [datalines-1:0]   lat_data;
    logic                   lat_wr;
    logic                   lat_both;
    logic [datalines-1:0]   hold;
    logic [datalines-1:0]   rd_val;
    logic                   lat_ok;
    logic                   load_ok;
    logic                   accept;
    logic                   mem_we;
    logic [aw-1:0]          mem_idx;
    logic [datalines-1:0]   mem_wd;

    logic [datalines-1:0] mem [0:memdepth-1];

    assign lat_ok  = {1'b0, lat_addr} < depth_lim;
    assign load_ok = {1'b0, load_addr} < depth_lim;
    assign accept  = (state == IDLE) && !load_en && (read || write);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = (ws4 == 4'd0) ? RESP : WAIT;
            WAIT: if (cnt <= 4'd1) state_nx = RESP;
            RESP: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            lat_addr <= '0;
            lat_data <= '0;
            lat_wr   <= 1'b0;
            lat_both <= 1'b0;
            hold     <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                lat_addr <= addressbus;
                lat_data <= toram;
                lat_wr   <= write;
                lat_both <= read && write;
                cnt      <= ws4;
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (state == RESP && !lat_wr) hold <= rd_val;
        end
    end

    // Store shares one write port between preload (IDLE only) and CU writes (RESP only)
    always_comb begin
        mem_we  = 1'b0;
        mem_idx = lat_addr[aw-1:0];
        mem_wd  = lat_data;
        if (!reset) begin
            if (state == IDLE && load_en && load_ok) begin
                mem_we  = 1'b1;
                mem_idx = load_addr[aw-1:0];
                mem_wd  = load_data;
            end else if (state == RESP && lat_wr && lat_ok) begin
                mem_we = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_idx] <= mem_wd;
    end

    assign rd_val  = lat_ok ? mem[lat_addr[aw-1:0]] : '0;
    assign fromram = (state == RESP && !lat_wr) ? rd_val : hold;
    assign ready   = (state == RESP);
    assign busy    = (state != IDLE);
    assign err     = (state == RESP) && (lat_both || !lat_ok);

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - randomized self-checking bench for mem_responder against an array model
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  addressbus [3];
    logic [15:0] toram      [3];
    logic [15:0] fromram    [3];
    logic [7:0]  load_addr  [3];
    logic [15:0] load_data  [3];
    logic [2:0]  read, write, ready, busy, err, load_en;

    always #5 clk = ~clk;

    // Instance 0: default build, 1: zero wait states, 2: 128-word store
    for (genvar g = 0; g < 3; g++) begin : g_dut
        mem_responder #(
            .adlines(8), .datalines(16),
            .memdepth(g == 2 ? 128 : 256),
            .waitstates(g == 1 ? 0 : 2)
        ) dut (
            .clk(clk), .reset(reset),
            .addressbus(addressbus[g]), .toram(toram[g]),
            .read(read[g]), .write(write[g]),
            .fromram(fromram[g]), .ready(ready[g]), .busy(busy[g]), .err(err[g]),
            .load_en(load_en[g]), .load_addr(load_addr[g]), .load_data(load_data[g])
        );
    end

    int          checks = 0;
    int          failures = 0;
    logic [15:0] model   [3][256];
    logic [15:0] last_rd [3];

    function automatic int ws(input int d);
        return (d == 1) ? 0 : 2;
    endfunction

    function automatic int depth(input int d);
        return (d == 2) ? 128 : 256;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int d, input int a, input logic [15:0] v);
        logic [7:0] a8;
        a8 = a[7:0];
        load_en[d] = 1'b1; load_addr[d] = a8; load_data[d] = v;
        @(posedge clk);
        @(negedge clk);
        load_en[d] = 1'b0;
        if (a < depth(d)) model[d][a] = v;
    endtask

    // side: 0 none, 1 change bus and drop request during WAIT, 2 preload pulse during WAIT
    task automatic access(input int d, input bit rd, input bit wr, input int a,
                          input logic [15:0] v, input int side);
        int          k;
        bit          got;
        logic [15:0] exp_data;
        logic [7:0]  a8;
        bit          exp_err;
        a8 = a[7:0];
        read[d] = rd; write[d] = wr; addressbus[d] = a8; toram[d] = v;
        exp_err  = (rd && wr) || (a >= depth(d));
        exp_data = wr ? last_rd[d] : ((a < depth(d)) ? model[d][a] : 16'h0);
        @(posedge clk);
        k = 0; got = 1'b0;
        while (!got && k < 40) begin
            @(negedge clk);
            k++;
            if (ready[d]) got = 1'b1;
            else begin
                chk($sformatf("d%0d busy_wait", d), busy[d], 1);
                chk($sformatf("d%0d err_wait", d), err[d], 0);
                if (k == 1 && side == 1) begin
                    addressbus[d] = a8 + 8'd1; toram[d] = ~v; read[d] = 1'b0; write[d] = 1'b0;
                end
                if (k == 1 && side == 2) begin
                    load_en[d] = 1'b1; load_addr[d] = a8; load_data[d] = ~model[d][a];
                end
                if (k == 2) load_en[d] = 1'b0;
            end
        end
        load_en[d] = 1'b0;
        if (!got) chk($sformatf("d%0d ready_timeout", d), 0, 1);
        chk($sformatf("d%0d latency a=%0d", d, a), k, ws(d) + 1);
        chk($sformatf("d%0d busy_resp", d), busy[d], 1);
        chk($sformatf("d%0d fromram a=%0d", d, a), fromram[d], exp_data);
        chk($sformatf("d%0d err a=%0d", d, a), err[d], exp_err);
        read[d] = 1'b0; write[d] = 1'b0;
        if (wr && a < depth(d)) model[d][a] = v;
        if (!wr) last_rd[d] = exp_data;
        @(negedge clk);
        chk($sformatf("d%0d ready_idle", d), ready[d], 0);
        chk($sformatf("d%0d busy_idle", d), busy[d], 0);
        chk($sformatf("d%0d fromram_hold", d), fromram[d], last_rd[d]);
    endtask

    initial begin
        reset = 1'b1;
        read = '0; write = '0; load_en = '0;
        for (int d = 0; d < 3; d++) begin
            addressbus[d] = '0; toram[d] = '0; load_addr[d] = '0; load_data[d] = '0;
            last_rd[d] = '0;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("d%0d rst_fromram", d), fromram[d], 0);
            chk($sformatf("d%0d rst_ready", d), ready[d], 0);
            chk($sformatf("d%0d rst_busy", d), busy[d], 0);
            chk($sformatf("d%0d rst_err", d), err[d], 0);
        end
        reset = 1'b0;
        @(negedge clk);

        for (int d = 0; d < 3; d++)
            for (int a = 0; a < depth(d); a++) load(d, a, 16'($urandom));

        // Directed scenarios
        load(0, 16, 16'd5); load(0, 17, 16'd2);
        access(0, 1, 0, 16, 16'h0, 0);
        access(0, 0, 1, 1, 16'h0086, 0);
        access(0, 1, 0, 1, 16'h0, 0);
        chk("d0 readback_0086", fromram[0], 16'h0086);
        load(1, 16, 16'd5); load(1, 17, 16'd2);
        access(1, 1, 0, 16, 16'h0, 0);
        chk("d1 b2b_first", fromram[1], 16'd5);
        access(1, 1, 0, 17, 16'h0, 0);
        chk("d1 b2b_second", fromram[1], 16'd2);
        access(0, 1, 0, 16, 16'h0, 1);
        chk("d0 latched_addr", fromram[0], 16'd5);
        access(2, 1, 0, 255, 16'h0, 0);
        access(2, 1, 1, 3, 16'd9, 0);
        access(2, 1, 0, 3, 16'h0, 0);
        chk("d2 both_is_write", fromram[2], 16'd9);
        access(0, 1, 0, 20, 16'h0, 2);

        // Reset during WAIT of a write aborts it
        load(0, 4, 16'd7);
        write[0] = 1'b1; addressbus[0] = 8'd4; toram[0] = 16'h1234;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_mid busy", busy[0], 0);
        chk("rst_mid ready", ready[0], 0);
        chk("rst_mid fromram", fromram[0], 0);
        write[0] = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("rst_mid no_ready", ready[0], 0);
        end
        reset = 1'b0;
        for (int d = 0; d < 3; d++) last_rd[d] = '0;
        @(negedge clk);
        access(0, 1, 0, 4, 16'h0, 0);
        chk("rst_mid mem4", fromram[0], 16'd7);

        // Randomized traffic
        repeat (150) begin
            int d, op, a;
            logic [15:0] v;
            d  = $urandom_range(0, 2);
            op = $urandom_range(0, 4);
            a  = $urandom_range(0, 255);
            v  = 16'($urandom);
            if (op == 4) load(d, a, v);
            else access(d, (op == 0 || op == 2 || op == 3), (op == 1 || op == 2), a, v, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the control unit's memory interface: `addressbus`, `read`, `write`, `toram`, `fromram`.
- Holds the program/data store and services one CU request at a time.
- Each access takes a programmable number of wait states; completion is signalled by a one-cycle `ready` pulse.
- A side-band load port preloads the store before the CU is enabled, replacing the bench-level direct RAM writes.

Parameters:
- adlines, 8, address bus width in bits.
- datalines, 16, data word width in bits.
- memdepth, 256, number of implemented words; must be ≤ 2^adlines.
- waitstates, 2, extra cycles between request acceptance and `ready` (0..15).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- addressbus  input  adlines  word address from the CU.
- toram  input  datalines  write data from the CU.
- read  input  1  CU read request, level; held until `ready`.
- write  input  1  CU write request, level; held until `ready`.
- fromram  output  datalines  read data to the CU.
- ready  output  1  one-cycle completion strobe.
- busy  output  1  high while a request is latched and not yet completed.
- err  output  1  one-cycle strobe on a bad request.
- load_en  input  1  preload write strobe.
- load_addr  input  adlines  preload address.
- load_data  input  datalines  preload data.

Behaviour:
- Reset (asynchronous, active-high):
  - `fromram`=0, `ready`=0, `busy`=0, `err`=0; state=IDLE; wait counter=0.
  - Memory contents are NOT cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If `load_en`=1: write `load_data` to `mem[load_addr]` at the clock edge. Any CU request that cycle is not latched; it is re-sampled next cycle.
  - Else if `read` or `write` is high: latch the address, `toram` and the operation.
    - Load the counter with `waitstates`.
    - Go to WAIT if `waitstates` > 0, else go to RESP.
    - `busy`=1 from the next cycle.
- WAIT: decrement the counter each cycle; when it reaches 1, go to RESP. WAIT therefore lasts exactly `waitstates` cycles.
- RESP, lasting one cycle:
  - `ready`=1.
  - Read: `fromram` is driven with `mem[latched addr]` in the same cycle.
  - Write: `mem[latched addr]` is updated at the end of the RESP cycle.
  - Next state is IDLE.
  - `busy` is high in WAIT and RESP, low in IDLE.
- Latency: request sampled in IDLE at edge N → `ready` high during cycle N+1+`waitstates`.
- `fromram` holds its last read value until the next read completes. Writes do not change `fromram`.
- `load_en` outside IDLE is ignored.
- Because the request is latched, later changes of `addressbus`/`toram` or deassertion of `read`/`write` do not affect the transaction in flight.
- A request still high in the IDLE cycle after `ready` starts a new transaction. The CU must drop its request on `ready`.
- `read` and `write` both high at acceptance: treated as a write; `err` pulses during the RESP cycle.
- Latched address ≥ `memdepth`:
  - Read returns 0 on `fromram`.
  - Write is dropped.
  - `err` pulses during the RESP cycle; `ready` still pulses.
- Reset mid-transaction: the transaction is aborted, no memory write occurs, and `ready` is not issued.

Test Plan:
- Preload `mem[16]`=5 and `mem[17]`=2 via the load port, then CU read addr 16 with `waitstates`=2. Required: `ready` exactly 3 cycles after the sampling edge; `fromram`=5; `busy` high for 3 cycles; `err`=0.
- CU write `mem[1]`=16'h0086, then read addr 1. Required: second `ready` returns 16'h0086; `fromram` unchanged between the write's `ready` and the read's `ready`.
- `waitstates`=0 build, back-to-back read 16 / read 17, with the request dropped on each `ready`. Required: `ready` on cycles N+1 and N+3; data 5 then 2.
- Change `addressbus` from 16 to 17 during WAIT on a read of 16. Required: `fromram`=5 (the latched address is used).
- Read addr 255 with `memdepth`=128. Required: `fromram`=0, `ready`=1 and `err`=1 in the same cycle. Then assert `read`+`write` together at addr 3 with `toram`=9: write performed (`mem[3]`=9) and `err` pulses.
- Assert `reset` during WAIT of a write to addr 4 (preloaded 7). Required: `ready` never asserted; `busy`=0 immediately; a subsequent read of addr 4 returns 7. Separately, `load_en` asserted during WAIT: memory unchanged.
